// File: rtl/alu_pkg.sv
// Shared ALU control codes, RISC-V opcodes, immediate kinds and the
// decode/slot record types used by the issue stage.
package alu_pkg;
  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_SLL  = 5'h02;
  localparam logic [4:0] ALU_SLT  = 5'h03;
  localparam logic [4:0] ALU_SLTU = 5'h04;
  localparam logic [4:0] ALU_XOR  = 5'h05;
  localparam logic [4:0] ALU_SRL  = 5'h06;
  localparam logic [4:0] ALU_SRA  = 5'h07;
  localparam logic [4:0] ALU_OR   = 5'h08;
  localparam logic [4:0] ALU_AND  = 5'h09;
  localparam logic [4:0] ALU_JALR = 5'h0A;
  localparam logic [4:0] ALU_BEQ  = 5'h0B;
  localparam logic [4:0] ALU_BNE  = 5'h0C;
  localparam logic [4:0] ALU_BLT  = 5'h0D;
  localparam logic [4:0] ALU_BGE  = 5'h0E;
  localparam logic [4:0] ALU_BLTU = 5'h0F;
  localparam logic [4:0] ALU_BGEU = 5'h10;
  localparam logic [4:0] ALU_IMM  = 5'h11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [31:0] op1, op2, imm, pc;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_we, is_load, is_store, is_branch, is_jump, illegal;
  } ex_t;

  typedef struct packed {
    ex_t  ex;
    logic uses_rs1, uses_rs2;
  } dec_t;

  // alt only distinguishes SUB/ADD and SRA/SRL
  function automatic logic [4:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_issue_if.sv
// Fetch-side, regfile and ID/EX slot signals of the ALU issue stage.
interface alu_issue_if;
  logic        if_valid, id_ready;
  logic [31:0] if_inst, if_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        flush, ex_ready, ex_valid;
  logic [4:0]  ex_alu_ctrl;
  logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_reg_we, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal;

  modport slave (
    input  if_valid, if_inst, if_pc, rs1_rdata, rs2_rdata, flush, ex_ready,
    output id_ready, rs1_addr, rs2_addr, ex_valid, ex_alu_ctrl, ex_op1, ex_op2,
           ex_imm, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_reg_we, ex_is_load,
           ex_is_store, ex_is_branch, ex_is_jump, ex_illegal
  );
  modport master (
    output if_valid, if_inst, if_pc, rs1_rdata, rs2_rdata, flush, ex_ready,
    input  id_ready, rs1_addr, rs2_addr, ex_valid, ex_alu_ctrl, ex_op1, ex_op2,
           ex_imm, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_reg_we, ex_is_load,
           ex_is_store, ex_is_branch, ex_is_jump, ex_illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational decode of one instruction into ALU code, operands,
// immediate and side-band flags.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  output dec_t        dec
);
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] immi, imms, immb, immu, immj, shamt;
  imm_t        isel;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign immi  = {{20{inst[31]}}, inst[31:20]};
  assign imms  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign immb  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign immu  = {inst[31:12], 12'b0};
  assign immj  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt = {27'b0, inst[24:20]};

  always_comb begin
    dec        = '0;
    isel       = IMM_I;
    dec.ex.ctrl = ALU_ADD;
    dec.ex.pc  = pc;
    dec.ex.rd  = inst[11:7];
    dec.ex.rs1 = inst[19:15];
    dec.ex.rs2 = inst[24:20];
    case (opc)
      OPC_OP: begin
        dec.ex.ctrl = alu_f3(f3, inst[30]);
        dec.ex.op1 = rs1_rdata; dec.ex.op2 = rs2_rdata; dec.ex.reg_we = 1'b1;
        dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        // immediate bit 10 is only an opcode modifier for right shifts
        dec.ex.ctrl = alu_f3(f3, inst[30] & (f3 == 3'b101));
        dec.ex.op1 = rs1_rdata;
        dec.ex.op2 = (f3 == 3'b001 || f3 == 3'b101) ? shamt : immi;
        dec.ex.reg_we = 1'b1; dec.uses_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        dec.ex.op1 = rs1_rdata; dec.ex.op2 = immi;
        dec.ex.reg_we = 1'b1; dec.ex.is_load = 1'b1; dec.uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        isel = IMM_S;
        dec.ex.op1 = rs1_rdata; dec.ex.op2 = imms; dec.ex.is_store = 1'b1;
        dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
      end
      OPC_LUI: begin
        isel = IMM_U;
        dec.ex.ctrl = ALU_IMM; dec.ex.op2 = immu; dec.ex.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        isel = IMM_U;
        dec.ex.op1 = pc; dec.ex.op2 = immu; dec.ex.reg_we = 1'b1;
      end
      OPC_JAL: begin
        isel = IMM_J;
        dec.ex.op1 = pc; dec.ex.op2 = immj;
        dec.ex.reg_we = 1'b1; dec.ex.is_jump = 1'b1;
      end
      OPC_JALR: begin
        dec.ex.ctrl = ALU_JALR;
        dec.ex.op1 = rs1_rdata; dec.ex.op2 = immi;
        dec.ex.reg_we = 1'b1; dec.ex.is_jump = 1'b1; dec.uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        isel = IMM_B;
        dec.ex.op1 = rs1_rdata; dec.ex.op2 = rs2_rdata;
        dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
        dec.ex.is_branch = 1'b1;
        case (f3)
          3'b000:  dec.ex.ctrl = ALU_BEQ;
          3'b001:  dec.ex.ctrl = ALU_BNE;
          3'b100:  dec.ex.ctrl = ALU_BLT;
          3'b101:  dec.ex.ctrl = ALU_BGE;
          3'b110:  dec.ex.ctrl = ALU_BLTU;
          3'b111:  dec.ex.ctrl = ALU_BGEU;
          default: begin dec.ex.illegal = 1'b1; dec.ex.is_branch = 1'b0; end
        endcase
      end
      default: dec.ex.illegal = 1'b1;
    endcase
    case (isel)
      IMM_S:   dec.ex.imm = imms;
      IMM_B:   dec.ex.imm = immb;
      IMM_U:   dec.ex.imm = immu;
      IMM_J:   dec.ex.imm = immj;
      default: dec.ex.imm = immi;
    endcase
    if (dec.ex.rd == 5'd0) dec.ex.reg_we = 1'b0;
  end
endmodule

// File: rtl/alu_issue.sv
// ID/EX issue slot: decodes the fetched instruction, stalls one cycle on a
// load-use hazard and drops the slot on a resolved branch/jump flush.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);
  dec_t dec;
  ex_t  slot;
  logic vld, adv, hazard;

  assign bus.rs1_addr = bus.if_inst[19:15];
  assign bus.rs2_addr = bus.if_inst[24:20];

  alu_decoder u_dec (
    .inst      (bus.if_inst),
    .pc        (bus.if_pc),
    .rs1_rdata (bus.rs1_rdata),
    .rs2_rdata (bus.rs2_rdata),
    .dec       (dec)
  );

  assign adv    = !vld | bus.ex_ready;
  assign hazard = vld & slot.is_load & (slot.rd != 5'd0) &
                  ((dec.uses_rs1 & (slot.rd == dec.ex.rs1)) |
                   (dec.uses_rs2 & (slot.rd == dec.ex.rs2)));
  assign bus.id_ready = bus.flush | (adv & !hazard);

  // Empty slot is zeroed so flags read 0 whenever ex_valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      slot <= '0;
    end else if (bus.flush || (adv && hazard)) begin
      vld  <= 1'b0;
      slot <= '0;
    end else if (adv) begin
      vld  <= bus.if_valid;
      slot <= bus.if_valid ? dec.ex : '0;
    end
  end

  assign bus.ex_valid     = vld;
  assign bus.ex_alu_ctrl  = slot.ctrl;
  assign bus.ex_op1       = slot.op1;
  assign bus.ex_op2       = slot.op2;
  assign bus.ex_imm       = slot.imm;
  assign bus.ex_pc        = slot.pc;
  assign bus.ex_rd        = slot.rd;
  assign bus.ex_rs1       = slot.rs1;
  assign bus.ex_rs2       = slot.rs2;
  assign bus.ex_reg_we    = slot.reg_we;
  assign bus.ex_is_load   = slot.is_load;
  assign bus.ex_is_store  = slot.is_store;
  assign bus.ex_is_branch = slot.is_branch;
  assign bus.ex_is_jump   = slot.is_jump;
  assign bus.ex_illegal   = slot.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode cases, load-use bubble, EX stall,
// flush and asynchronous reset.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [31:0] regs [32];

  alu_issue_if bus();

  alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.rs1_rdata = regs[bus.rs1_addr];
  assign bus.rs2_rdata = regs[bus.rs2_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    bus.if_valid = 1'b0;
    bus.if_inst  = 32'd0;
    bus.if_pc    = 32'd0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;

    #12;
    chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_ctrl", {27'd0, bus.ex_alu_ctrl}, 32'd0);
    chk("rst_we", {31'd0, bus.ex_reg_we}, 32'd0);
    chk("rst_id_ready", {31'd0, bus.id_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // add x3,x1,x2
    drive(32'h002081B3, 32'h100);
    #1 chk("add_rs1_addr", {27'd0, bus.rs1_addr}, 32'd1);
    tick();
    chk("add_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("add_ctrl", {27'd0, bus.ex_alu_ctrl}, 32'h0);
    chk("add_op1", bus.ex_op1, 32'd5);
    chk("add_op2", bus.ex_op2, 32'd7);
    chk("add_rd", {27'd0, bus.ex_rd}, 32'd3);
    chk("add_we", {31'd0, bus.ex_reg_we}, 32'd1);
    chk("add_pc", bus.ex_pc, 32'h100);

    // srai x4,x1,3 / slli x4,x1,3
    drive(32'h4030D213, 32'h104);
    tick();
    chk("srai_ctrl", {27'd0, bus.ex_alu_ctrl}, 32'h7);
    chk("srai_op2", bus.ex_op2, 32'd3);
    drive(32'h00309213, 32'h108);
    tick();
    chk("slli_ctrl", {27'd0, bus.ex_alu_ctrl}, 32'h2);
    chk("slli_op2", bus.ex_op2, 32'd3);

    // lw x5,0(x1) then dependent add x6,x5,x2
    drive(32'h0000A283, 32'h10C);
    tick();
    chk("lw_load", {31'd0, bus.ex_is_load}, 32'd1);
    chk("lw_rd", {27'd0, bus.ex_rd}, 32'd5);
    drive(32'h00228333, 32'h110);
    #1 chk("hazard_id_ready", {31'd0, bus.id_ready}, 32'd0);
    tick();
    chk("bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("bubble_load", {31'd0, bus.ex_is_load}, 32'd0);
    chk("after_bubble_ready", {31'd0, bus.id_ready}, 32'd1);
    tick();
    chk("dep_add_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("dep_add_rd", {27'd0, bus.ex_rd}, 32'd6);
    chk("dep_add_op2", bus.ex_op2, 32'd7);

    // bge x1,x2,-8 and the illegal funct3=010 branch
    drive(32'hFE20DCE3, 32'h200);
    tick();
    chk("bge_ctrl", {27'd0, bus.ex_alu_ctrl}, 32'hE);
    chk("bge_imm", bus.ex_imm, 32'hFFFFFFF8);
    chk("bge_we", {31'd0, bus.ex_reg_we}, 32'd0);
    chk("bge_branch", {31'd0, bus.ex_is_branch}, 32'd1);
    drive(32'hFE20ACE3, 32'h204);
    tick();
    chk("badbr_illegal", {31'd0, bus.ex_illegal}, 32'd1);
    chk("badbr_branch", {31'd0, bus.ex_is_branch}, 32'd0);

    // addi x0,x0,1 and lui x7,0x12345
    drive(32'h00100013, 32'h208);
    tick();
    chk("addi_x0_we", {31'd0, bus.ex_reg_we}, 32'd0);
    chk("addi_x0_op2", bus.ex_op2, 32'd1);
    drive(32'h123453B7, 32'h20C);
    tick();
    chk("lui_ctrl", {27'd0, bus.ex_alu_ctrl}, 32'h11);
    chk("lui_op2", bus.ex_op2, 32'h12345000);
    chk("lui_we", {31'd0, bus.ex_reg_we}, 32'd1);

    // EX back-pressure for three cycles, then flush while stalled
    bus.ex_ready = 1'b0;
    drive(32'h002081B3, 32'h210);
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_id_ready", {31'd0, bus.id_ready}, 32'd0);
      tick();
      chk("stall_ctrl", {27'd0, bus.ex_alu_ctrl}, 32'h11);
      chk("stall_op2", bus.ex_op2, 32'h12345000);
      chk("stall_pc", bus.ex_pc, 32'h20C);
    end
    bus.flush = 1'b1;
    #1 chk("flush_id_ready", {31'd0, bus.id_ready}, 32'd1);
    tick();
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    bus.ex_ready = 1'b1;
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("flush_we", {31'd0, bus.ex_reg_we}, 32'd0);
    tick();
    chk("flush_dropped", {31'd0, bus.ex_valid}, 32'd0);

    // asynchronous reset mid-cycle
    drive(32'h002081B3, 32'h300);
    tick();
    chk("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("async_rst_we", {31'd0, bus.ex_reg_we}, 32'd0);
    bus.if_valid = 1'b0;
    #3 rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/issue stage that feeds the ALU: it takes fetched instructions and produces the 5-bit ALU control code, selected operands and side-band control. The result is held in a registered ID/EX slot with a valid/ready handshake. Load-use hazard bubbles and branch/jump flushes are handled here. It sits between the fetch stage and the EX stage; ALU-code generation is centralised here.

## Interface
- Parameters: none (XLEN fixed at 32).
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch presents an instruction
- if_inst  in  32  instruction word
- if_pc  in  32  PC of if_inst
- id_ready  out  1  instruction accepted this cycle when if_valid & id_ready
- rs1_addr, rs2_addr  out  5 each  combinational regfile read addresses (if_inst[19:15], [24:20])
- rs1_rdata, rs2_rdata  in  32 each  regfile read data, same cycle
- flush  in  1  taken branch/jump resolved in EX; kill the slot
- ex_ready  in  1  EX consumes the slot this cycle
- ex_valid  out  1  slot holds a live instruction
- ex_alu_ctrl  out  5  ALU code
- ex_op1, ex_op2  out  32 each  ALU operands
- ex_imm, ex_pc  out  32 each  immediate (branch/store offset), instruction PC
- ex_rd, ex_rs1, ex_rs2  out  5 each  register indices, for EX forwarding
- ex_reg_we, ex_is_load, ex_is_store, ex_is_branch, ex_is_jump, ex_illegal  out  1 each

## Operation
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, JALR 0xA, BEQ 0xB, BNE 0xC, BLT 0xD, BGE 0xE, BLTU 0xF, BGEU 0x10, IMM 0x11.
- OP (0110011): funct3 selects the code; funct7[5] selects SUB over ADD and SRA over SRL. op1=rs1, op2=rs2, we=1.
- OP-IMM (0010011): same mapping, op2=immI. funct7[5] is honoured only for shifts, and op2 is then shamt zero-extended.
- LOAD/STORE: ADD, op1=rs1, op2=immI or immS. STORE has we=0 and ex_imm=immS.
- LUI: IMM, op2=immU. AUIPC: ADD, op1=pc, op2=immU.
- JAL: ADD, op1=pc, op2=immJ, we=1, is_jump.
- JALR: JALR code, op1=rs1, op2=immI, we=1, is_jump.
- BRANCH: funct3 000/001/100/101/110/111 map to BEQ/BNE/BLT/BGE/BLTU/BGEU. op1=rs1, op2=rs2, ex_imm=immB, we=0. Funct3 010/011 are illegal.
- Any other opcode: ex_illegal=1, code ADD, we=0, all other flags 0.
- Immediates are sign-extended from inst[31]. ex_reg_we is forced to 0 when rd=0.
- Load-use hazard = ex_valid & ex_is_load & ex_rd≠0 & (ex_rd matches a source register the decoded instruction reads). rs2 counts only for OP, STORE and BRANCH.
- Slot advance condition: adv = !ex_valid | ex_ready.
- id_ready = flush | (adv & !hazard).

## Timing
- Reset: ex_valid=0, all ex_* data and flags 0. id_ready follows its equation, so it is 1 after reset.
- Latency: one cycle. An instruction accepted at edge N appears on ex_* after edge N.
- Priority at each edge:
  1. flush: ex_valid←0, and any incoming instruction is discarded.
  2. else if adv & hazard: insert a bubble (ex_valid←0). Fetch holds.
  3. else if adv: ex_valid←if_valid, and data is loaded when if_valid.
  4. else: hold all ex_* stable.
- When ex_valid=0, ex_* data are don't-care. Flags must be 0.
- Hazard stall lasts exactly one cycle, because the load leaves the slot.
- Asynchronous reset asserted mid-stall or mid-flush clears the slot immediately.

## Structure
- Package alu_pkg holds: the ALU code localparams, opcode constants, and an immediate-type enum (I/S/B/U/J).
- Sub-module alu_decoder: purely combinational, if_inst→code, operand selects, immediate, flags.
- alu_issue itself contains the hazard logic and the slot register.

## Test plan
- add x3,x1,x2 with x1=5, x2=7 → one cycle later ex_valid=1, ctrl=0, op1=5, op2=7, rd=3, we=1.
- srai x4,x1,3 (0x4030D213) → ctrl=7, op2=3. slli → ctrl=2.
- lw x5,0(x1) followed by add x6,x5,x2 → id_ready=0 for one cycle, a bubble in the slot, then the add issues.
- bge x1,x2,-8 → ctrl=0xE, ex_imm=0xFFFFFFF8, we=0, is_branch=1. Funct3=010 → ex_illegal=1.
- ex_ready=0 for 3 cycles while if_valid=1 → ex_* stable and id_ready=0. Flush in the same cycle → ex_valid=0 next cycle and the fetched instruction is dropped.
- addi x0,x0,1 → we=0. Reset asserted asynchronously mid-stream → ex_valid=0 with no clock edge.
